// File: rtl/dma_scheduler.sv
// dma_scheduler: two-requester front end for a DMA engine.
// Requests are arbitrated into a small FIFO and issued to the engine one at a
// time. Write transactions wait for the engine busy handshake (rise, then
// fall); read transactions complete after a fixed two-cycle hold.
// A request arriving at an empty FIFO while the engine is free bypasses the
// FIFO storage so it issues on the very next cycle.
// Optional macro DMA_SCHED_RR_EN: round-robin arbitration instead of fixed
// priority (requester 0 over requester 1).
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no transaction outstanding; issue head (or bypassed request)
// WAIT_HI | write issued, waiting for engine_busy to rise
// WAIT_LO | write accepted by engine, waiting for engine_busy to fall
// WAIT_RD | read issued, holding for the fixed read delay
module dma_scheduler #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 7,
    parameter int DAT_W  = 18
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 req_valid,
    input  logic [1:0]                 req_we,
    input  logic [2*ADDR_W-1:0]        req_addr,
    input  logic [2*DAT_W-1:0]         req_dat,
    output logic [1:0]                 req_ready,
    output logic                       issue_valid,
    output logic                       issue_we,
    output logic [ADDR_W-1:0]          issue_addr,
    output logic [DAT_W-1:0]           issue_dat,
    output logic                       issue_id,
    input  logic                       engine_busy,
    output logic                       done_valid,
    output logic                       done_id,
    output logic                       done_we,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       sched_busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_HI = 2'd1,
        WAIT_LO = 2'd2,
        WAIT_RD = 2'd3
    } state_t;

    state_t state;

    logic              mem_we   [DEPTH];
    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DAT_W-1:0]  mem_dat  [DEPTH];
    logic              mem_id   [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              rd_timer;

    logic [1:0]        grant;
    logic              full;
    logic              accept;
    logic              sel;
    logic              in_we;
    logic [ADDR_W-1:0] in_addr;
    logic [DAT_W-1:0]  in_dat;
    logic              pop;
    logic              bypass;
    logic              push;
    logic              launch_we;
    logic [ADDR_W-1:0] launch_addr;
    logic [DAT_W-1:0]  launch_dat;
    logic              launch_id;

`ifdef DMA_SCHED_RR_EN
    // Requester favoured on contention; the one not granted last.
    logic rr_ptr;

    // Pick the favoured requester under contention, otherwise the lone requester.
    always_comb begin
        grant = 2'b00;
        if (req_valid == 2'b11)
            grant = rr_ptr ? 2'b10 : 2'b01;
        else
            grant = req_valid;
    end

    // Move the favoured requester away from whoever was actually accepted.
    always_ff @(posedge clk) begin
        if (reset)
            rr_ptr <= 1'b0;
        else if (accept)
            rr_ptr <= ~sel;
    end
`else
    // Fixed priority: requester 0 always wins.
    always_comb begin
        grant = 2'b00;
        if (req_valid[0])
            grant = 2'b01;
        else if (req_valid[1])
            grant = 2'b10;
    end
`endif

    // Accept logic: a full FIFO refuses even if the head pops this cycle.
    always_comb begin
        full      = (fifo_count == CNT_W'(DEPTH));
        req_ready = (reset || full) ? 2'b00 : grant;
        accept    = |(req_valid & req_ready);
        sel       = req_ready[1];
        in_we     = sel ? req_we[1] : req_we[0];
        in_addr   = sel ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
        in_dat    = sel ? req_dat[2*DAT_W-1:DAT_W]    : req_dat[DAT_W-1:0];
    end

    // Launch decision: head of FIFO first, else bypass a fresh request.
    always_comb begin
        pop         = (state == IDLE) && !engine_busy && (fifo_count != '0);
        bypass      = (state == IDLE) && !engine_busy && (fifo_count == '0) && accept;
        push        = accept && !bypass;
        launch_we   = pop ? mem_we[rd_ptr]   : in_we;
        launch_addr = pop ? mem_addr[rd_ptr] : in_addr;
        launch_dat  = pop ? mem_dat[rd_ptr]  : in_dat;
        launch_id   = pop ? mem_id[rd_ptr]   : sel;
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_we[wr_ptr]   <= in_we;
            mem_addr[wr_ptr] <= in_addr;
            mem_dat[wr_ptr]  <= in_dat;
            mem_id[wr_ptr]   <= sel;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Transaction sequencer with registered issue and completion outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rd_timer    <= 1'b0;
            issue_valid <= 1'b0;
            issue_we    <= 1'b0;
            issue_addr  <= '0;
            issue_dat   <= '0;
            issue_id    <= 1'b0;
            done_valid  <= 1'b0;
            done_id     <= 1'b0;
            done_we     <= 1'b0;
        end else begin
            issue_valid <= 1'b0;
            done_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop || bypass) begin
                        issue_valid <= 1'b1;
                        issue_we    <= launch_we;
                        issue_addr  <= launch_addr;
                        issue_dat   <= launch_dat;
                        issue_id    <= launch_id;
                        rd_timer    <= 1'b1;
                        state       <= launch_we ? WAIT_HI : WAIT_RD;
                    end
                end
                WAIT_HI: begin
                    if (engine_busy)
                        state <= WAIT_LO;
                end
                WAIT_LO: begin
                    if (!engine_busy) begin
                        done_valid <= 1'b1;
                        done_id    <= issue_id;
                        done_we    <= issue_we;
                        state      <= IDLE;
                    end
                end
                WAIT_RD: begin
                    if (rd_timer == 1'b0) begin
                        done_valid <= 1'b1;
                        done_id    <= issue_id;
                        done_we    <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        rd_timer <= rd_timer - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Busy whenever a transaction is outstanding or work is queued.
    always_comb begin
        sched_busy = (state != IDLE) || (fifo_count != '0);
    end

endmodule

// File: tb/tb_dma_scheduler.sv
// Directed self-checking bench for dma_scheduler (default parameters).
// Expected arbitration order follows DMA_SCHED_RR_EN when it is defined.
module tb_dma_scheduler;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 7;
    localparam int DAT_W  = 18;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [1:0]           req_valid;
    logic [1:0]           req_we;
    logic [2*ADDR_W-1:0]  req_addr;
    logic [2*DAT_W-1:0]   req_dat;
    logic [1:0]           req_ready;
    logic                 issue_valid;
    logic                 issue_we;
    logic [ADDR_W-1:0]    issue_addr;
    logic [DAT_W-1:0]     issue_dat;
    logic                 issue_id;
    logic                 engine_busy;
    logic                 done_valid;
    logic                 done_id;
    logic                 done_we;
    logic [2:0]           fifo_count;
    logic                 sched_busy;

    int n_tests = 0;
    int n_fail  = 0;

    dma_scheduler #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DAT_W(DAT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_dat     (req_dat),
        .req_ready   (req_ready),
        .issue_valid (issue_valid),
        .issue_we    (issue_we),
        .issue_addr  (issue_addr),
        .issue_dat   (issue_dat),
        .issue_id    (issue_id),
        .engine_busy (engine_busy),
        .done_valid  (done_valid),
        .done_id     (done_id),
        .done_we     (done_we),
        .fifo_count  (fifo_count),
        .sched_busy  (sched_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int         n_done;
    int         n_iss;
    logic       seen_id;
    logic       seen_we;
    logic [3:0] ids;
    logic [3:0] exp_ids;

    initial begin
`ifdef DMA_SCHED_RR_EN
        exp_ids = 4'b1010;
`else
        exp_ids = 4'b0000;
`endif
        reset       = 1'b1;
        req_valid   = 2'b11;
        req_we      = 2'b00;
        req_addr    = '0;
        req_dat     = '0;
        engine_busy = 1'b0;
        ids         = '0;

        // reset state
        step();
        step();
        check("rst_count", fifo_count, 0);
        check("rst_issue_valid", issue_valid, 0);
        check("rst_done_valid", done_valid, 0);
        check("rst_sched_busy", sched_busy, 0);
        check("rst_issue_addr", issue_addr, 0);
        check("rst_ready", req_ready, 2'b00);
        req_valid = 2'b00;
        reset     = 1'b0;
        step();

        // write from requester 0 with full busy handshake
        req_valid = 2'b01;
        req_we    = 2'b01;
        req_addr  = {7'h00, 7'h05};
        req_dat   = {18'h0, 18'h12345};
        #1;
        check("wr_ready", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        check("wr_issue_valid", issue_valid, 1);
        check("wr_issue_addr", issue_addr, 7'h05);
        check("wr_issue_dat", issue_dat, 18'h12345);
        check("wr_issue_we", issue_we, 1);
        check("wr_issue_id", issue_id, 0);
        check("wr_count_bypass", fifo_count, 0);
        step();
        check("wr_issue_pulse", issue_valid, 0);
        engine_busy = 1'b1;
        n_done = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (done_valid) n_done++;
        end
        check("wr_no_early_done", n_done, 0);
        engine_busy = 1'b0;
        seen_id = 1'b1;
        seen_we = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (done_valid) begin
                n_done++;
                seen_id = done_id;
                seen_we = done_we;
            end
        end
        check("wr_done_count", n_done, 1);
        check("wr_done_id", seen_id, 0);
        check("wr_done_we", seen_we, 1);

        // read from requester 1, done two cycles after issue
        req_valid = 2'b10;
        req_we    = 2'b00;
        req_addr  = {7'h10, 7'h00};
        req_dat   = {18'h00abc, 18'h0};
        #1;
        check("rd_ready", req_ready, 2'b10);
        step();
        req_valid = 2'b00;
        check("rd_issue_valid", issue_valid, 1);
        check("rd_issue_id", issue_id, 1);
        check("rd_issue_we", issue_we, 0);
        check("rd_issue_addr", issue_addr, 7'h10);
        step();
        check("rd_done_early", done_valid, 0);
        step();
        check("rd_done_valid", done_valid, 1);
        check("rd_done_id", done_id, 1);
        check("rd_done_we", done_we, 0);
        step();
        check("rd_done_pulse", done_valid, 0);
        check("rd_idle", sched_busy, 0);

        // contention fill with engine busy
        engine_busy = 1'b1;
        req_valid   = 2'b11;
        req_we      = 2'b00;
        req_addr    = {7'h42, 7'h21};
        for (int i = 0; i < 4; i++) step();
        check("fill_count", fifo_count, 4);
        check("fill_ready", req_ready, 2'b00);
        check("fill_busy", sched_busy, 1);
        check("fill_no_issue", issue_valid, 0);

        // full FIFO: one pop, ready blocked in pop cycle, reasserts after
        engine_busy = 1'b0;
        #1;
        check("full_pop_ready", req_ready, 2'b00);
        step();
        check("pop_count", fifo_count, 3);
        check("pop_issue_valid", issue_valid, 1);
        ids[0] = issue_id;
        check("pop_ready_back", req_ready, 2'b01);
        req_valid   = 2'b00;
        engine_busy = 1'b1;
        n_iss = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (issue_valid) n_iss++;
        end
        check("single_pop_issues", n_iss, 0);
        check("single_pop_count", fifo_count, 3);

        // drain remaining entries and check FIFO order
        engine_busy = 1'b0;
        n_iss = 1;
        for (int i = 0; i < 40 && n_iss < 4; i++) begin
            step();
            if (issue_valid) begin
                ids[n_iss] = issue_id;
                n_iss++;
            end
        end
        check("drain_issues", n_iss, 4);
        check("arb_order", ids, exp_ids);
        for (int i = 0; i < 10 && sched_busy; i++) step();
        check("drain_idle", sched_busy, 0);
        check("drain_count", fifo_count, 0);

        // reset in WAIT_LO with two entries queued
        req_valid = 2'b01;
        req_we    = 2'b01;
        req_addr  = {7'h00, 7'h33};
        step();
        check("mid_issue", issue_valid, 1);
        req_valid   = 2'b11;
        req_we      = 2'b11;
        engine_busy = 1'b1;
        step();
        step();
        req_valid = 2'b00;
        check("mid_count", fifo_count, 2);
        reset       = 1'b1;
        engine_busy = 1'b0;
        step();
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_done", done_valid, 0);
        check("mid_rst_busy", sched_busy, 0);
        req_valid = 2'b01;
        req_we    = 2'b00;
        req_addr  = {7'h00, 7'h55};
        #1;
        check("rst_no_accept", req_ready, 2'b00);
        step();
        check("mid_rst_done2", done_valid, 0);
        reset = 1'b0;
        #1;
        check("post_rst_ready", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        check("post_issue_valid", issue_valid, 1);
        check("post_issue_addr", issue_addr, 7'h55);
        check("post_issue_we", issue_we, 0);
        n_done = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (done_valid) n_done++;
        end
        check("post_done_count", n_done, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
